// File: rtl/pressure_ctrl_pkg.sv
// Shared state encoding, default parameters and sizing helper for the pressure controller.
package pressure_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RAMP_UP = 2'd1,
    RAMP_DN = 2'd2
  } state_t;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_P_LOW  = 0;
  localparam int DEF_P_HIGH = 200;
  localparam int DEF_STEP   = 10;
  localparam int DEF_DIV    = 2;

  // A divide-by-1 counter still needs one bit to hold its single value.
  function automatic int cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/pressure_ctrl_if.sv
// Control requests in, registered chamber status out; master drives requests, slave is the controller.
interface pressure_ctrl_if
  import pressure_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             startPressurization;
  logic             startDepressurization;
  logic             abort;
  logic [WIDTH-1:0] pressure;
  logic             busy;
  logic             atHigh;
  logic             atLow;
  logic             done;
  logic             conflict;

  modport master (
    output startPressurization, startDepressurization, abort,
    input  pressure, busy, atHigh, atLow, done, conflict
  );

  modport slave (
    input  startPressurization, startDepressurization, abort,
    output pressure, busy, atHigh, atLow, done, conflict
  );
endinterface

// File: rtl/pressure_tick.sv
// Ramp step divider: tick is high on every DIV-th cycle after clear drops; held quiet while clear is high.
// No latency beyond the registered count; no backpressure.
module pressure_tick
  import pressure_ctrl_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam int            CW   = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/pressure_ctrl.sv
// Chamber pressure ramp controller: steps pressure toward P_HIGH/P_LOW every DIV cycles on request.
// All outputs registered, one-cycle latency from a sampled request; no backpressure, abort wins over a due step.
module pressure_ctrl
  import pressure_ctrl_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int P_LOW  = DEF_P_LOW,
  parameter int P_HIGH = DEF_P_HIGH,
  parameter int STEP   = DEF_STEP,
  parameter int DIV    = DEF_DIV
) (
  input  logic           clock,
  input  logic           reset,
  pressure_ctrl_if.slave bus
);
  localparam logic [WIDTH-1:0] PL     = WIDTH'(P_LOW);
  localparam logic [WIDTH-1:0] PH     = WIDTH'(P_HIGH);
  localparam logic [WIDTH-1:0] ST     = WIDTH'(STEP);
  localparam logic [WIDTH:0]   PH_X   = (WIDTH+1)'(P_HIGH);
  localparam logic [WIDTH:0]   DN_MIN = (WIDTH+1)'(P_LOW + STEP);

  state_t           state;
  logic             tick;
  logic             sp_q;
  logic             sd_q;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH-1:0] up_val;
  logic [WIDTH-1:0] dn_val;

  assign up_sum = {1'b0, bus.pressure} + {1'b0, ST};
  assign up_val = (up_sum >= PH_X) ? PH : up_sum[WIDTH-1:0];
  assign dn_val = ({1'b0, bus.pressure} >= DN_MIN) ? (bus.pressure - ST) : PL;

  pressure_tick #(.DIV(DIV)) u_tick (
    .clock (clock),
    .reset (reset),
    .clear (state == IDLE),
    .tick  (tick)
  );

  // A start toward a bound already held acknowledges with done once per request
  // assertion, so a level held past the end of a ramp does not stream done pulses.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      bus.pressure <= PH;
      bus.atHigh   <= 1'b1;
      bus.atLow    <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.conflict <= 1'b0;
      sp_q         <= 1'b0;
      sd_q         <= 1'b0;
    end else begin
      bus.done     <= 1'b0;
      bus.conflict <= 1'b0;
      sp_q         <= bus.startPressurization;
      sd_q         <= bus.startDepressurization;
      case (state)
        IDLE: begin
          if (bus.startPressurization && bus.startDepressurization) begin
            bus.conflict <= 1'b1;
          end else if (bus.startPressurization) begin
            if (bus.atHigh) begin
              if (!sp_q) bus.done <= 1'b1;
            end else begin
              state    <= RAMP_UP;
              bus.busy <= 1'b1;
            end
          end else if (bus.startDepressurization) begin
            if (bus.atLow) begin
              if (!sd_q) bus.done <= 1'b1;
            end else begin
              state    <= RAMP_DN;
              bus.busy <= 1'b1;
            end
          end
        end
        RAMP_UP: begin
          if (bus.abort) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else if (tick) begin
            bus.pressure <= up_val;
            bus.atHigh   <= (up_val == PH);
            bus.atLow    <= 1'b0;
            if (up_val == PH) begin
              state    <= IDLE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
            end
          end
        end
        RAMP_DN: begin
          if (bus.abort) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else if (tick) begin
            bus.pressure <= dn_val;
            bus.atHigh   <= 1'b0;
            bus.atLow    <= (dn_val == PL);
            if (dn_val == PL) begin
              state    <= IDLE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pressure_ctrl.sv
// Two controllers (defaults, and STEP=30/DIV=1) share one stimulus stream and are
// compared every cycle against an arithmetic model of the ramp rules.
module tb_pressure_ctrl;

  logic clock = 1'b0;
  logic reset;
  logic sp, sd, ab;

  always #5 clock = ~clock;

  pressure_ctrl_if #(.WIDTH(8)) ia ();
  pressure_ctrl_if #(.WIDTH(8)) ib ();

  assign ia.startPressurization   = sp;
  assign ia.startDepressurization = sd;
  assign ia.abort                 = ab;
  assign ib.startPressurization   = sp;
  assign ib.startDepressurization = sd;
  assign ib.abort                 = ab;

  pressure_ctrl u_a (
    .clock (clock),
    .reset (reset),
    .bus   (ia.slave)
  );

  pressure_ctrl #(.STEP(30), .DIV(1)) u_b (
    .clock (clock),
    .reset (reset),
    .bus   (ib.slave)
  );

  int ph_m[2] = '{200, 200};
  int pl_m[2] = '{0, 0};
  int st_m[2] = '{10, 30};
  int dv_m[2] = '{2, 1};

  // mode: 0 idle, 1 rising, 2 falling; cyc counts cycles since ramp entry
  int m_mode[2];
  int m_p[2];
  int m_cyc[2];
  bit m_psp[2];
  bit m_psd[2];
  bit m_done[2];
  bit m_conf[2];

  int tests = 0;
  int fails = 0;
  int dn_a  = 0;
  int b_max = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input int k);
    int bound;
    if (!reset) begin
      m_mode[k] = 0;
      m_p[k]    = ph_m[k];
      m_cyc[k]  = 0;
      m_done[k] = 0;
      m_conf[k] = 0;
      m_psp[k]  = 0;
      m_psd[k]  = 0;
      return;
    end
    m_done[k] = 0;
    m_conf[k] = 0;
    if (m_mode[k] == 0) begin
      if (sp && sd) begin
        m_conf[k] = 1;
      end else if (sp) begin
        if (m_p[k] == ph_m[k]) m_done[k] = !m_psp[k];
        else begin m_mode[k] = 1; m_cyc[k] = 0; end
      end else if (sd) begin
        if (m_p[k] == pl_m[k]) m_done[k] = !m_psd[k];
        else begin m_mode[k] = 2; m_cyc[k] = 0; end
      end
    end else if (ab) begin
      m_mode[k] = 0;
    end else begin
      m_cyc[k]++;
      if (m_cyc[k] % dv_m[k] == 0) begin
        if (m_mode[k] == 1) begin
          m_p[k] = (m_p[k] + st_m[k] > ph_m[k]) ? ph_m[k] : m_p[k] + st_m[k];
          bound  = ph_m[k];
        end else begin
          m_p[k] = (m_p[k] - st_m[k] < pl_m[k]) ? pl_m[k] : m_p[k] - st_m[k];
          bound  = pl_m[k];
        end
        if (m_p[k] == bound) begin
          m_done[k] = 1;
          m_mode[k] = 0;
        end
      end
    end
    m_psp[k] = sp;
    m_psd[k] = sd;
  endtask

  task automatic check_outputs();
    check("a.pressure", ia.pressure, m_p[0]);
    check("a.busy",     ia.busy,     m_mode[0] != 0);
    check("a.atHigh",   ia.atHigh,   m_p[0] == ph_m[0]);
    check("a.atLow",    ia.atLow,    m_p[0] == pl_m[0]);
    check("a.done",     ia.done,     m_done[0]);
    check("a.conflict", ia.conflict, m_conf[0]);
    check("b.pressure", ib.pressure, m_p[1]);
    check("b.busy",     ib.busy,     m_mode[1] != 0);
    check("b.atHigh",   ib.atHigh,   m_p[1] == ph_m[1]);
    check("b.atLow",    ib.atLow,    m_p[1] == pl_m[1]);
    check("b.done",     ib.done,     m_done[1]);
    check("b.conflict", ib.conflict, m_conf[1]);
  endtask

  task automatic step();
    @(posedge clock);
    model_edge(0);
    model_edge(1);
    #1;
    check_outputs();
    dn_a += int'(ia.done);
    if (int'(ib.pressure) > b_max) b_max = int'(ib.pressure);
  endtask

  initial begin
    reset = 1'b0;
    sp    = 1'b0;
    sd    = 1'b0;
    ab    = 1'b0;
    repeat (2) step();
    check("rst_pressure", ia.pressure, 200);
    reset = 1'b1;
    step();

    // full descent from one-cycle request
    sd = 1'b1;
    step();
    sd = 1'b0;
    dn_a = 0;
    repeat (50) step();
    check("dn_done_cnt", dn_a, 1);
    check("dn_final", ia.pressure, 0);
    check("dn_atlow", ia.atLow, 1);

    // held request: one ramp, one done, no re-trigger at the bound
    sp = 1'b1;
    dn_a = 0;
    repeat (60) step();
    sp = 1'b0;
    check("up_done_cnt", dn_a, 1);
    check("up_final", ia.pressure, 200);

    sp = 1'b1;
    sd = 1'b1;
    step();
    sp = 1'b0;
    sd = 1'b0;
    check("conf_pulse", ia.conflict, 1);
    step();
    check("conf_clear", ia.conflict, 0);

    // abort five steps into a descent
    sd = 1'b1;
    step();
    sd = 1'b0;
    repeat (10) step();
    check("pre_abort", ia.pressure, 150);
    ab = 1'b1;
    step();
    ab = 1'b0;
    check("abort_hold", ia.pressure, 150);
    check("abort_busy", ia.busy, 0);
    dn_a = 0;
    repeat (10) step();
    check("abort_no_done", dn_a, 0);

    // reset mid-ramp
    sd = 1'b1;
    step();
    sd = 1'b0;
    repeat (5) step();
    reset = 1'b0;
    step();
    check("midrst_pressure", ia.pressure, 200);
    check("midrst_busy", ia.busy, 0);
    reset = 1'b1;
    step();

    for (int i = 0; i < 1500; i++) begin
      sp    = ($urandom_range(0, 99) < 12);
      sd    = ($urandom_range(0, 99) < 12);
      ab    = ($urandom_range(0, 99) < 5);
      reset = !($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b1;
    check("b_max", b_max, 200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
